word_serializer: RTL
====================

# word_serializer

Parallel-in, serial-out word shifter; the unloading counterpart of the RAM-based shift register. It accepts a block of up to C_DEPTH words in one handshake and presents them one word per accepted transfer on a valid/ready stream, word 0 first. It sits between block-producing stages (FFT output, symbol buffers) and sample-serial consumers in the receive datapath.

## Interface
- C_WIDTH, 16, bits per word
- C_DEPTH, 16, maximum words per block (≥2)
- C_ADDR_WIDTH, 5, width of LEN and internal count; must hold the value C_DEPTH
- CLK  in  1  rising-edge clock
- ACLR_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; 0 freezes all state and forces both ready/valid handshakes to fail
- SCLR  in  1  synchronous clear (CE-qualified); same effect as reset
- D  in  C_WIDTH*C_DEPTH  load block; word i = D[i*C_WIDTH +: C_WIDTH]
- LEN  in  C_ADDR_WIDTH  words to emit, sampled at load
- LOAD_VALID  in  1  load request
- LOAD_READY  out  1  load accept
- Q  out  C_WIDTH  current output word
- Q_VALID  out  1  Q holds a valid word
- Q_READY  in  1  consumer accepts Q
- Q_LAST  out  1  present only with WORD_SERIALIZER_LAST_EN

## Operation
- States: IDLE (no data held), SHIFT (REMAIN ≥1 words pending).
- Load fires on LOAD_VALID & LOAD_READY & CE: shreg ← D, REMAIN ← effective LEN, state ← SHIFT.
- Effective LEN: LEN in 1..C_DEPTH used as is; LEN=0 or LEN>C_DEPTH treated as C_DEPTH.
- Q = shreg word 0; Q_VALID = (state==SHIFT).
- Transfer fires on Q_VALID & Q_READY & CE: shreg shifts down one word (word i ← word i+1, top word ← 0), REMAIN decrements.
- Transfer with REMAIN==1: state ← IDLE and shreg cleared, unless a load fires the same cycle, which takes priority (state stays SHIFT, shreg ← D).
- LOAD_READY = CE & ACLR_N & (IDLE | (transfer firing with REMAIN==1)); combinational from Q_READY, giving zero-bubble back-to-back blocks.
- LOAD_VALID while in SHIFT with REMAIN>1: ignored, held off by LOAD_READY=0.
- SCLR: priority over load and transfer; the cycle it is sampled with CE=1 ends in IDLE with all registers zero. With CE=0, SCLR has no effect.
- Words beyond effective LEN are never emitted.

## Timing
- Reset (ACLR_N low, asynchronous): state IDLE, REMAIN 0, shreg 0 → Q=0, Q_VALID=0, Q_LAST=0; LOAD_READY=0 while ACLR_N is low, 1 from the first cycle after release if CE=1.
- Latency: the load edge is followed by Q_VALID=1 and Q=word 0 in the next cycle.
- Throughput: one word per cycle with Q_READY held high; a block of N words occupies exactly N cycles, with no gap between blocks.
- Q_VALID and Q are stable while Q_VALID & !Q_READY, including across CE=0 cycles.
- Reset mid-block: block discarded immediately; Q_VALID drops asynchronously.

## Configuration
- WORD_SERIALIZER_LAST_EN defined: port Q_LAST exists, and Q_LAST = Q_VALID & (REMAIN==1), with the same timing as Q.
- Not defined: no Q_LAST port and no associated logic; all other behaviour is identical.

## Structure
- Package word_serializer_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a clog2 constant function;
  - the effective-length function (LEN clamp).
- One sub-module, word_serializer_ctrl, holds the FSM, REMAIN counter, LOAD_READY/Q_VALID/Q_LAST generation, and the load/shift strobes. The top level holds the shreg datapath.

## Test plan
- Reset then load D words = 0x0000..0x000F, LEN=16, Q_READY=1 → Q=0x0000..0x000F on 16 consecutive cycles starting one cycle after load; Q_VALID falls after the last word; LOAD_READY rises in the same cycle as the last transfer.
- LEN=3, Q_READY toggling 1,0,0,1,1 → Q=w0,w1,w1,w1,w2; Q stable while stalled; Q_LAST=1 only with w2 (macro defined).
- LEN=0 and LEN=20 → 16 words emitted in each case.
- Two blocks, second LOAD_VALID asserted continuously, Q_READY=1 → last word of block A is followed next cycle by word 0 of block B, no idle cycle.
- CE=0 for 4 cycles mid-block → no Q advance, LOAD_READY=0; resume continues at the same word.
- ACLR_N pulsed low mid-block, then SCLR=1 mid-block in a separate run → Q_VALID=0, Q=0 immediately for reset and on the next edge for SCLR; the next load emits correctly from word 0.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// ============================================================================
// Module : word_serializer_pkg
// Brief  : Shared types and helpers for the word_serializer block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package word_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Out-of-range lengths (0 or above the block size) mean "whole block".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_serializer_if.sv
// ============================================================================
// Module : word_serializer_if
// Brief  : Load and output stream bundle; Q_LAST exists only with
//          WORD_SERIALIZER_LAST_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface word_serializer_if #(
    parameter int C_WIDTH      = 16,
    parameter int C_DEPTH      = 16,
    parameter int C_ADDR_WIDTH = 5
);
    logic [C_WIDTH*C_DEPTH-1:0] D;
    logic [C_ADDR_WIDTH-1:0]    LEN;
    logic                       LOAD_VALID;
    logic                       LOAD_READY;
    logic [C_WIDTH-1:0]         Q;
    logic                       Q_VALID;
    logic                       Q_READY;
`ifdef WORD_SERIALIZER_LAST_EN
    logic                       Q_LAST;

    modport slave  (input  D, LEN, LOAD_VALID, Q_READY,
                    output LOAD_READY, Q, Q_VALID, Q_LAST);
    modport master (output D, LEN, LOAD_VALID, Q_READY,
                    input  LOAD_READY, Q, Q_VALID, Q_LAST);
`else
    modport slave  (input  D, LEN, LOAD_VALID, Q_READY,
                    output LOAD_READY, Q, Q_VALID);
    modport master (output D, LEN, LOAD_VALID, Q_READY,
                    input  LOAD_READY, Q, Q_VALID);
`endif
endinterface

`default_nettype wire

// File: rtl/word_serializer_ctrl.sv
// ============================================================================
// Module : word_serializer_ctrl
// Brief  : IDLE/SHIFT FSM, remaining-word counter and handshake strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer_ctrl
    import word_serializer_pkg::*;
#(
    parameter int C_DEPTH      = 16,
    parameter int C_ADDR_WIDTH = 5
) (
    input  wire logic                    clk_i,
    input  wire logic                    aclr_n_i,
    input  wire logic                    ce_i,
    input  wire logic                    sclr_i,
    input  wire logic                    load_valid_i,
    input  wire logic                    q_ready_i,
    input  wire logic [C_ADDR_WIDTH-1:0] len_i,
    output logic                         load_ready_o,
    output logic                         load_fire_o,
    output logic                         shift_fire_o,
    output logic                         clear_o,
    output logic                         q_valid_o
`ifdef WORD_SERIALIZER_LAST_EN
    ,
    output logic                         q_last_o
`endif
);

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] remain_q, remain_d;
    logic                    last_beat;
    logic                    xfer;
    logic                    sclr_fire;
    logic [C_ADDR_WIDTH-1:0] len_eff;

    assign len_eff   = C_ADDR_WIDTH'(eff_len(32'(len_i), 32'(C_DEPTH)));
    assign last_beat = (remain_q == C_ADDR_WIDTH'(1));
    assign q_valid_o = (state_q == ST_SHIFT);
    assign xfer      = q_valid_o & q_ready_i & ce_i;
    assign sclr_fire = ce_i & sclr_i;

    // Ready while draining the final word lets the next block follow with no bubble.
    assign load_ready_o = ce_i & aclr_n_i & ((state_q == ST_IDLE) | (xfer & last_beat));
    assign load_fire_o  = load_valid_i & load_ready_o;
    assign shift_fire_o = xfer;
    assign clear_o      = sclr_fire | (xfer & last_beat & ~load_fire_o);

`ifdef WORD_SERIALIZER_LAST_EN
    assign q_last_o = q_valid_o & last_beat;
`endif

    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (sclr_fire) begin
            state_d  = ST_IDLE;
            remain_d = '0;
        end else if (load_fire_o) begin
            state_d  = ST_SHIFT;
            remain_d = len_eff;
        end else if (xfer) begin
            remain_d = remain_q - C_ADDR_WIDTH'(1);
            if (last_beat) begin
                state_d = ST_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module : word_serializer
// Brief  : Parallel-in, serial-out word shifter (block load, valid/ready out).
//          Optional Q_LAST output enabled by WORD_SERIALIZER_LAST_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int C_WIDTH      = 16,
    parameter int C_DEPTH      = 16,
    parameter int C_ADDR_WIDTH = 5
) (
    input  wire logic         CLK,
    input  wire logic         ACLR_N,
    input  wire logic         CE,
    input  wire logic         SCLR,
    word_serializer_if.slave  bus
);

    logic [C_DEPTH-1:0][C_WIDTH-1:0] shreg_q;
    logic                            load_fire;
    logic                            shift_fire;
    logic                            clear;

    word_serializer_ctrl #(
        .C_DEPTH      (C_DEPTH),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_ctrl (
        .clk_i        (CLK),
        .aclr_n_i     (ACLR_N),
        .ce_i         (CE),
        .sclr_i       (SCLR),
        .load_valid_i (bus.LOAD_VALID),
        .q_ready_i    (bus.Q_READY),
        .len_i        (bus.LEN),
        .load_ready_o (bus.LOAD_READY),
        .load_fire_o  (load_fire),
        .shift_fire_o (shift_fire),
        .clear_o      (clear),
        .q_valid_o    (bus.Q_VALID)
`ifdef WORD_SERIALIZER_LAST_EN
        ,
        .q_last_o     (bus.Q_LAST)
`endif
    );

    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            shreg_q <= '0;
        end else if (clear) begin
            shreg_q <= '0;
        end else if (load_fire) begin
            shreg_q <= bus.D;
        end else if (shift_fire) begin
            shreg_q <= {{C_WIDTH{1'b0}}, shreg_q[C_DEPTH-1:1]};
        end
    end

    assign bus.Q = shreg_q[0];

endmodule

`default_nettype wire
